// File: rtl/qupls_checkpoint_ctrl.sv
// qupls_checkpoint_ctrl
//   Rename-map checkpoint manager. Slots form a circular in-order queue:
//   branches allocate at the tail, commit frees at the head. On a restore
//   the selected checkpoint is read from the checkpoint RAM in one cycle,
//   captured, and streamed back into the rename map one bank per cycle.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   alloc_req/ack/id      checkpoint allocation handshake (combinational ack)
//   free_req              oldest checkpoint retired
//   restore_req/id        roll back to a live checkpoint
//   restore_busy/done/err restore status (done/err are one-cycle pulses)
//   ckpt_wr_en/addr       checkpoint RAM write port (write on grant edge)
//   ckpt_rd_en/addr/data  checkpoint RAM zero-latency read port
//   map_wr/bank/data      rename-map bank write
//   full, empty, count    queue status
module qupls_checkpoint_ctrl #(
    parameter int NCHECK = 16,
    parameter int AREGS  = 64,
    parameter int PREGS  = 512,
    parameter int BANKS  = 4,
    localparam int RBIT  = $clog2(PREGS),
    localparam int CW    = $clog2(NCHECK),
    localparam int BW    = $clog2(BANKS),
    localparam int SL    = AREGS * RBIT,
    localparam int WID   = SL * BANKS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alloc_req,
    output logic            alloc_ack,
    output logic [CW-1:0]   alloc_id,
    input  logic            free_req,
    input  logic            restore_req,
    input  logic [CW-1:0]   restore_id,
    output logic            restore_busy,
    output logic            restore_done,
    output logic            restore_err,
    output logic            ckpt_wr_en,
    output logic [CW-1:0]   ckpt_wr_addr,
    output logic            ckpt_rd_en,
    output logic [CW-1:0]   ckpt_rd_addr,
    input  logic [WID-1:0]  ckpt_rd_data,
    output logic            map_wr,
    output logic [BW-1:0]   map_bank,
    output logic [SL-1:0]   map_data,
    output logic            full,
    output logic            empty,
    output logic [CW:0]     count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW:0]   PTR_ONE   = 1;
    localparam logic [CW:0]   DEPTH     = NCHECK[CW:0];
    localparam logic [BW-1:0] BANK_ONE  = 1;
    localparam logic [BW-1:0] BANK_LAST = BW'(BANKS - 1);

    logic [1:0]     state;
    logic [CW:0]    head, tail;     // extra MSB is the wrap bit
    logic [CW-1:0]  id_r;
    logic [BW-1:0]  bank;
    logic [WID-1:0] cap;
    logic           err_r;

    logic           idle, restore_go, live, free_go;
    logic [CW-1:0]  offset;

    assign idle       = (state == S_IDLE);
    assign count      = tail - head;
    assign full       = (count == DEPTH);
    assign empty      = (count == '0);

    // Distance of the requested slot from the head, modulo the ring size.
    // Evaluated against the pre-free count so a same-cycle free of the
    // restored slot is still a legal restore.
    assign offset     = restore_id - head[CW-1:0];
    assign live       = ({1'b0, offset} < count);
    assign restore_go = idle && restore_req;
    assign free_go    = free_req && !empty;

    // A restore request in IDLE takes priority over allocation, live or not.
    assign alloc_ack    = alloc_req && !full && idle && !restore_req;
    assign alloc_id     = tail[CW-1:0];
    assign ckpt_wr_en   = alloc_ack;
    assign ckpt_wr_addr = tail[CW-1:0];

    assign ckpt_rd_en   = (state == S_RD);
    assign ckpt_rd_addr = id_r;

    assign map_wr       = (state == S_XFER);
    assign map_bank     = map_wr ? bank : '0;
    assign map_data     = map_wr ? cap[bank*SL +: SL] : '0;

    assign restore_busy = !idle;
    assign restore_done = (state == S_DONE);
    assign restore_err  = err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            head  <= '0;
            tail  <= '0;
            id_r  <= '0;
            bank  <= '0;
            cap   <= '0;
            err_r <= 1'b0;
        end else begin
            err_r <= restore_go && !live;

            if (free_go)
                head <= head + PTR_ONE;

            // Restore discards every checkpoint younger than the restored one.
            if (restore_go && live)
                tail <= head + {1'b0, offset} + PTR_ONE;
            else if (alloc_ack)
                tail <= tail + PTR_ONE;

            case (state)
                S_IDLE: begin
                    if (restore_go && live) begin
                        id_r  <= restore_id;
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    cap   <= ckpt_rd_data;
                    bank  <= '0;
                    state <= S_XFER;
                end
                S_XFER: begin
                    bank <= bank + BANK_ONE;
                    if (bank == BANK_LAST)
                        state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qupls_checkpoint_ctrl.sv
// Randomized + directed bench for qupls_checkpoint_ctrl. A reference model
// tracks live checkpoints as a queue of slot ids and a copy of the RAM
// contents; per-cycle expectations go into a scoreboard queue that a
// negedge monitor pops and compares.
module tb_qupls_checkpoint_ctrl;

    localparam int NCHECK = 16;
    localparam int AREGS  = 64;
    localparam int PREGS  = 512;
    localparam int BANKS  = 4;
    localparam int RBIT   = 9;
    localparam int CW     = 4;
    localparam int BW     = 2;
    localparam int SL     = AREGS * RBIT;
    localparam int WID    = SL * BANKS;

    logic            clk, rst_n;
    logic            alloc_req, alloc_ack;
    logic [CW-1:0]   alloc_id;
    logic            free_req, restore_req;
    logic [CW-1:0]   restore_id;
    logic            restore_busy, restore_done, restore_err;
    logic            ckpt_wr_en, ckpt_rd_en;
    logic [CW-1:0]   ckpt_wr_addr, ckpt_rd_addr;
    logic [WID-1:0]  ckpt_rd_data;
    logic            map_wr;
    logic [BW-1:0]   map_bank;
    logic [SL-1:0]   map_data;
    logic            full, empty;
    logic [CW:0]     count;

    qupls_checkpoint_ctrl #(.NCHECK(NCHECK), .AREGS(AREGS), .PREGS(PREGS), .BANKS(BANKS)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_id(alloc_id),
        .free_req(free_req),
        .restore_req(restore_req), .restore_id(restore_id),
        .restore_busy(restore_busy), .restore_done(restore_done), .restore_err(restore_err),
        .ckpt_wr_en(ckpt_wr_en), .ckpt_wr_addr(ckpt_wr_addr),
        .ckpt_rd_en(ckpt_rd_en), .ckpt_rd_addr(ckpt_rd_addr), .ckpt_rd_data(ckpt_rd_data),
        .map_wr(map_wr), .map_bank(map_bank), .map_data(map_data),
        .full(full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment checkpoint RAM: written with the bench's current pattern.
    logic [WID-1:0] wpat;
    logic [WID-1:0] ram [NCHECK];
    always @(posedge clk) if (ckpt_wr_en) ram[ckpt_wr_addr] <= wpat;
    assign ckpt_rd_data = ram[ckpt_rd_addr];

    typedef struct packed {
        logic          ack;
        logic [CW-1:0] id;
        logic          rd_en;
        logic [CW-1:0] rd_addr;
        logic          map_wr;
        logic [BW-1:0] bank;
        logic [SL-1:0] data;
        logic          done, err, busy;
        logic [CW:0]   cnt;
        logic          full, empty;
    } exp_t;

    exp_t q[$];
    exp_t me;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string nm, input logic [SL-1:0] act, input logic [SL-1:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    endtask

    // Reference model state
    int             live[$];       // live slot ids, oldest first
    int             next_id;
    int             phase;         // 0 idle, 1 read, 2..BANKS+1 transfer, BANKS+2 done
    int             rid;
    bit             err_pend;
    logic [WID-1:0] mem [NCHECK];

    task automatic model_clear();
        live.delete();
        next_id  = 0;
        phase    = 0;
        rid      = 0;
        err_pend = 0;
    endtask

    task automatic new_pat();
        for (int i = 0; i < WID/32; i++) wpat[i*32 +: 32] = $urandom();
    endtask

    // One clock cycle of stimulus; expectations for this cycle are queued,
    // then the model advances to the state after the edge.
    task automatic cycle(input bit a, input bit f, input bit r, input int id);
        exp_t e;
        int   sz, idx;
        @(posedge clk); #1;
        new_pat();
        alloc_req   = a;
        free_req    = f;
        restore_req = r;
        restore_id  = id[CW-1:0];
        sz = live.size();
        e = '0;
        e.busy    = (phase != 0);
        e.ack     = a && phase == 0 && !r && sz < NCHECK;
        e.id      = next_id[CW-1:0];
        e.rd_en   = (phase == 1);
        e.rd_addr = rid[CW-1:0];
        e.map_wr  = (phase >= 2 && phase <= BANKS + 1);
        if (e.map_wr) begin
            e.bank = BW'(phase - 2);
            e.data = mem[rid][(phase-2)*SL +: SL];
        end
        e.done  = (phase == BANKS + 2);
        e.err   = err_pend;
        e.cnt   = sz[CW:0];
        e.full  = (sz == NCHECK);
        e.empty = (sz == 0);
        q.push_back(e);

        err_pend = 0;
        if (phase != 0) begin
            phase = (phase == BANKS + 2) ? 0 : phase + 1;
        end else if (r) begin
            idx = -1;
            foreach (live[i]) if (live[i] == id && idx < 0) idx = i;
            if (idx >= 0) begin
                while (live.size() > idx + 1) void'(live.pop_back());
                next_id = (id + 1) % NCHECK;
                rid     = id;
                phase   = 1;
            end else begin
                err_pend = 1;
            end
        end
        if (e.ack) begin
            live.push_back(next_id);
            mem[next_id] = wpat;
            next_id = (next_id + 1) % NCHECK;
        end
        if (f && sz > 0) void'(live.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        alloc_req = 0; free_req = 0; restore_req = 0; restore_id = '0;
        rst_n = 0;
        #1;
        chk("rst alloc_ack", alloc_ack, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst count", count, 0);
        chk("rst busy", restore_busy, 0);
        chk("rst map_wr", map_wr, 0);
        chk("rst map_data", map_data, 0);
        chk("rst done", restore_done, 0);
        chk("rst err", restore_err, 0);
        chk("rst rd_en", ckpt_rd_en, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (q.size() != 0) begin
            me = q.pop_front();
            chk("alloc_ack", alloc_ack, me.ack);
            chk("ckpt_wr_en", ckpt_wr_en, me.ack);
            if (me.ack) begin
                chk("alloc_id", alloc_id, me.id);
                chk("ckpt_wr_addr", ckpt_wr_addr, me.id);
            end
            chk("ckpt_rd_en", ckpt_rd_en, me.rd_en);
            if (me.rd_en) chk("ckpt_rd_addr", ckpt_rd_addr, me.rd_addr);
            chk("map_wr", map_wr, me.map_wr);
            if (me.map_wr) begin
                chk("map_bank", map_bank, me.bank);
                chk("map_data", map_data, me.data);
            end
            chk("restore_done", restore_done, me.done);
            chk("restore_err", restore_err, me.err);
            chk("restore_busy", restore_busy, me.busy);
            chk("count", count, me.cnt);
            chk("full", full, me.full);
            chk("empty", empty, me.empty);
        end
    end

    initial begin
        rst_n = 0;
        alloc_req = 0; free_req = 0; restore_req = 0; restore_id = '0;
        wpat = '0;
        model_clear();

        // Fill and overflow
        do_reset();
        repeat (17) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Wrap-around
        do_reset();
        repeat (12) cycle(1, 0, 0, 0);
        repeat (10) cycle(0, 1, 0, 0);
        repeat (10) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Restore of slot 2 followed by an alloc
        do_reset();
        repeat (5) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 2);
        repeat (6) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Restore of a non-live slot (head=3, tail=6, id=7)
        do_reset();
        repeat (6) cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 1, 0, 0);
        cycle(0, 0, 1, 7);
        repeat (2) cycle(0, 0, 0, 0);

        // Simultaneous events
        do_reset();
        repeat (4) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 1, 2);
        repeat (7) cycle(1, 0, 0, 0);
        // Free of the restored slot in the accept cycle
        cycle(0, 1, 1, live[0]);
        repeat (7) cycle(0, 0, 0, 0);

        // Reset during transfer of bank 1
        do_reset();
        repeat (4) cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 2);
        while (phase < 3) cycle(0, 0, 0, 0);
        @(posedge clk); #2;
        chk("pre-rst map_wr", map_wr, 1);
        chk("pre-rst map_bank", map_bank, 1);
        #1 rst_n = 0;
        #1;
        chk("mid-rst map_wr", map_wr, 0);
        chk("mid-rst busy", restore_busy, 0);
        chk("mid-rst empty", empty, 1);
        chk("mid-rst count", count, 0);
        model_clear();
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit a, f, r;
            int id;
            a  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 9) < 4);
            r  = ($urandom_range(0, 99) < 6);
            id = $urandom_range(0, NCHECK - 1);
            cycle(a, f, r, id);
        end
        cycle(0, 0, 0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
